// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    // Access width codes carried on mem_width_in (3 behaves as a word).
    localparam logic [1:0] MemByte = 2'd0;
    localparam logic [1:0] MemHalf = 2'd1;
    localparam logic [1:0] MemWord = 2'd2;

    // Level driven on ram_wr_out.
    localparam logic ReadEnable  = 1'b0;
    localparam logic WriteEnable = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        LD_RD,
        ST_WR,
        DONE
    } state_e;

    // Index of the last byte of an access: number of bytes minus one.
    function automatic logic [2:0] last_byte_idx(input logic [1:0] width);
        case (width)
            MemByte: return 3'd0;
            MemHalf: return 3'd1;
            default: return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// Zero/sign extension of an assembled load word according to access width.
// Latency: combinational.
// Backpressure: none.
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic        signed_i,
    input  logic [31:0] raw_i,
    output logic [31:0] res_o
);

    // Replicate the top bit of the valid bytes when signed, zeros otherwise.
    always_comb begin
        res_o = raw_i;
        case (width_i)
            MemByte: res_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
            MemHalf: res_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
            MemWord: res_o = raw_i;
            default: res_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one 8-bit RAM port between instruction fetch and load/store, one byte per cycle.
// Latency: read of N bytes done in cycle N+2 after grant sample, write done in cycle N+1.
// Backpressure: requests are held level until done; stallreq_out holds the pipeline meanwhile.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    input  logic              if_cancel_in,
    output logic [31:0]       if_data_out,
    output logic              if_done_out,
    input  logic              mem_load_in,
    input  logic              mem_store_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [31:0]       mem_wdata_in,
    input  logic [1:0]        mem_width_in,
    input  logic              mem_signed_in,
    output logic [31:0]       mem_rdata_out,
    output logic              mem_done_out,
    input  logic [7:0]        ram_din_in,
    output logic [7:0]        ram_dout_out,
    output logic [ADDR_W-1:0] ram_a_out,
    output logic              ram_wr_out,
    output logic              stallreq_out
);

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;          // cycles spent in the current transfer state
    logic [2:0]        last_q, last_d;    // index of the final byte
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [1:0]        width_q, width_d;
    logic              sgn_q, sgn_d;
    logic              fetch_q, fetch_d;  // current/last grant belongs to fetch
    logic [31:0]       data_q, data_d;    // assembled read bytes
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;

    logic [2:0]        nxt_k;
    logic [1:0]        cap_idx;

    // State and RAM-facing registers; async reset leaves the port idle and quiet.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            k_q        <= '0;
            last_q     <= '0;
            base_q     <= '0;
            wdat_q     <= '0;
            width_q    <= MemByte;
            sgn_q      <= 1'b0;
            fetch_q    <= 1'b0;
            data_q     <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= ReadEnable;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            last_q     <= last_d;
            base_q     <= base_d;
            wdat_q     <= wdat_d;
            width_q    <= width_d;
            sgn_q      <= sgn_d;
            fetch_q    <= fetch_d;
            data_q     <= data_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
        end
    end

    // Arbitration, byte sequencing and read-data assembly.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        last_d     = last_q;
        base_d     = base_q;
        wdat_d     = wdat_q;
        width_d    = width_q;
        sgn_d      = sgn_q;
        fetch_d    = fetch_q;
        data_d     = data_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = ram_wr_q;
        nxt_k      = k_q + 3'd1;
        // RAM data lags the address by one cycle, so the byte arriving now is k-1.
        cap_idx    = k_q[1:0] - 2'd1;

        case (state_q)
            IDLE: begin
                if (mem_load_in || mem_store_in) begin
                    base_d  = mem_addr_in;
                    wdat_d  = mem_wdata_in;
                    width_d = mem_width_in;
                    sgn_d   = mem_signed_in;
                    fetch_d = 1'b0;
                    last_d  = last_byte_idx(mem_width_in);
                    k_d     = '0;
                    data_d  = '0;
                    ram_a_d = mem_addr_in;
                    if (mem_load_in) begin
                        state_d  = LD_RD;
                        ram_wr_d = ReadEnable;
                    end else begin
                        state_d    = ST_WR;
                        ram_wr_d   = WriteEnable;
                        ram_dout_d = mem_wdata_in[7:0];
                    end
                end else if (if_req_in && !if_cancel_in) begin
                    base_d   = if_addr_in;
                    fetch_d  = 1'b1;
                    last_d   = 3'd3;
                    k_d      = '0;
                    data_d   = '0;
                    ram_a_d  = if_addr_in;
                    ram_wr_d = ReadEnable;
                    state_d  = IF_RD;
                end
            end
            IF_RD, LD_RD: begin
                if (state_q == IF_RD && if_cancel_in) begin
                    state_d = IDLE;
                    k_d     = '0;
                    data_d  = '0;
                end else begin
                    if (k_q != 3'd0) begin
                        data_d[{cap_idx, 3'b000} +: 8] = ram_din_in;
                    end
                    if (k_q == last_q + 3'd1) begin
                        state_d = DONE;
                        k_d     = '0;
                    end else begin
                        k_d = nxt_k;
                        if (k_q < last_q) begin
                            ram_a_d = base_q + ADDR_W'(nxt_k);
                        end
                    end
                end
            end
            ST_WR: begin
                if (k_q == last_q) begin
                    state_d  = DONE;
                    ram_wr_d = ReadEnable;
                    k_d      = '0;
                end else begin
                    k_d        = nxt_k;
                    ram_a_d    = base_q + ADDR_W'(nxt_k);
                    ram_dout_d = wdat_q[{nxt_k[1:0], 3'b000} +: 8];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_ctrl_ext u_ext (
        .width_i  (width_q),
        .signed_i (sgn_q),
        .raw_i    (data_q),
        .res_o    (mem_rdata_out)
    );

    assign if_data_out  = data_q;
    assign if_done_out  = (state_q == DONE) &&  fetch_q;
    assign mem_done_out = (state_q == DONE) && !fetch_q;
    assign ram_a_out    = ram_a_q;
    assign ram_dout_out = ram_dout_q;
    assign ram_wr_out   = ram_wr_q;
    assign stallreq_out = (mem_load_in | mem_store_in) & ~mem_done_out;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: RAM model, high-level reference memory, queued expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_ctrl;

    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req_in, if_cancel_in;
    logic [31:0] if_addr_in;
    logic [31:0] if_data_out;
    logic        if_done_out;
    logic        mem_load_in, mem_store_in, mem_signed_in;
    logic [31:0] mem_addr_in, mem_wdata_in;
    logic [1:0]  mem_width_in;
    logic [31:0] mem_rdata_out;
    logic        mem_done_out;
    logic [7:0]  ram_din_in, ram_dout_out;
    logic [31:0] ram_a_out;
    logic        ram_wr_out, stallreq_out;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_cancel_in  (if_cancel_in),
        .if_data_out   (if_data_out),
        .if_done_out   (if_done_out),
        .mem_load_in   (mem_load_in),
        .mem_store_in  (mem_store_in),
        .mem_addr_in   (mem_addr_in),
        .mem_wdata_in  (mem_wdata_in),
        .mem_width_in  (mem_width_in),
        .mem_signed_in (mem_signed_in),
        .mem_rdata_out (mem_rdata_out),
        .mem_done_out  (mem_done_out),
        .ram_din_in    (ram_din_in),
        .ram_dout_out  (ram_dout_out),
        .ram_a_out     (ram_a_out),
        .ram_wr_out    (ram_wr_out),
        .stallreq_out  (stallreq_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
    } bus_t;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] data;
    } exp_t;

    bus_t bq[$];
    exp_t dq[$];
    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int cur_data_done_cyc = -1;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [7:0] defb(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : defb(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : defb(a);
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    // Little-endian integer read from the reference memory, optionally sign-adjusted.
    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n, input bit sgn);
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_rd(a + 32'(k))) << (8 * k);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Synchronous RAM: data for an address appears on the next cycle.
    always @(posedge clk_in) begin
        ram_din_in <= ram_rd(ram_a_out);
        if (ram_wr_out) ram_mem[ram_a_out] = ram_dout_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram_mem[a] = b;
        ref_mem[a] = b;
    endtask

    // Expected bus activity and completion for an access sampled in cycle g.
    task automatic push_op(input int kind, input logic [31:0] a, input logic [1:0] w,
                           input bit s, input logic [31:0] wd, input int g);
        int   n;
        bus_t b;
        exp_t e;
        n = (kind == K_FETCH) ? 4 : nbytes(w);
        for (int k = 0; k < n; k++) begin
            b.cyc = g + 1 + k;
            b.a   = a + 32'(k);
            b.wr  = (kind == K_STORE);
            b.d   = 8'(wd >> (8 * k));
            if (kind == K_STORE) ref_mem[b.a] = b.d;
            bq.push_back(b);
        end
        e.kind = kind;
        if (kind == K_STORE) begin
            e.cyc  = g + n + 1;
            e.data = '0;
        end else begin
            e.cyc  = g + n + 2;
            e.data = ref_read(a, n, s && kind == K_LOAD);
        end
        dq.push_back(e);
        if (kind != K_FETCH) cur_data_done_cyc = e.cyc;
    endtask

    task automatic wait_done(input bit fetch);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_in);
            if (fetch ? if_done_out : mem_done_out) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: no done pulse within 40 cycles (fetch=%0d)", fetch);
        end
        #1;
    endtask

    task automatic do_op(input int kind, input logic [31:0] a, input logic [1:0] w,
                         input bit s, input logic [31:0] wd);
        @(posedge clk_in);
        #1;
        if (kind == K_FETCH) begin
            if_req_in  = 1'b1;
            if_addr_in = a;
        end else begin
            mem_load_in   = (kind == K_LOAD);
            mem_store_in  = (kind == K_STORE);
            mem_addr_in   = a;
            mem_width_in  = w;
            mem_signed_in = s;
            mem_wdata_in  = wd;
        end
        push_op(kind, a, w, s, wd, cyc);
        wait_done(kind == K_FETCH);
        if_req_in    = 1'b0;
        mem_load_in  = 1'b0;
        mem_store_in = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ram_wr"},   ram_wr_out,    0);
        chk({tag, "_ram_a"},    ram_a_out,     0);
        chk({tag, "_ram_dout"}, ram_dout_out,  0);
        chk({tag, "_if_done"},  if_done_out,   0);
        chk({tag, "_mem_done"}, mem_done_out,  0);
        chk({tag, "_if_data"},  if_data_out,   0);
        chk({tag, "_mem_rdata"}, mem_rdata_out, 0);
    endtask

    // Monitor: compares RAM bus, completions and stall against the queued expectations.
    always @(negedge clk_in) begin
        bus_t b;
        exp_t e;
        if (rst_in) begin
            if (bq.size() != 0 && bq[0].cyc == cyc) begin
                b = bq.pop_front();
                chk("ram_a", ram_a_out, b.a);
                chk("ram_wr", ram_wr_out, b.wr);
                if (b.wr) chk("ram_dout", ram_dout_out, b.d);
            end else if (ram_wr_out) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: ram_wr_out=1 at %h, required 0 (cycle %0d)", ram_a_out, cyc);
            end
            if (if_done_out || mem_done_out) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: if_done=%0d mem_done=%0d, none required (cycle %0d)",
                             if_done_out, mem_done_out, cyc);
                end else begin
                    e = dq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    if (e.kind == K_FETCH) begin
                        chk("if_done", if_done_out, 1);
                        chk("if_data", if_data_out, e.data);
                    end else begin
                        chk("mem_done", mem_done_out, 1);
                        chk("if_done_quiet", if_done_out, 0);
                        if (e.kind == K_LOAD) chk("mem_rdata", mem_rdata_out, e.data);
                    end
                end
            end
            chk("stallreq", stallreq_out,
                ((mem_load_in || mem_store_in) && cyc != cur_data_done_cyc) ? 1 : 0);
        end
    end

    initial begin
        int g;
        int kind;
        logic [31:0] a;

        rst_in        = 1'b0;
        if_req_in     = 1'b0;
        if_cancel_in  = 1'b0;
        if_addr_in    = '0;
        mem_load_in   = 1'b0;
        mem_store_in  = 1'b0;
        mem_addr_in   = '0;
        mem_wdata_in  = '0;
        mem_width_in  = '0;
        mem_signed_in = 1'b0;

        repeat (3) @(posedge clk_in);
        #1;
        chk_reset_outputs("reset");
        chk("reset_stall", stallreq_out, 0);
        rst_in = 1'b1;

        // Fetch of a little-endian instruction word.
        poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
        do_op(K_FETCH, 32'h1000, 2'd2, 1'b0, 32'h0);

        // Fetch and signed byte load in the same cycle: data wins, fetch follows DONE.
        poke(32'h20, 8'h80);
        @(posedge clk_in);
        #1;
        g = cyc;
        if_req_in = 1'b1; if_addr_in = 32'h3000;
        mem_load_in = 1'b1; mem_addr_in = 32'h20; mem_width_in = 2'd0; mem_signed_in = 1'b1;
        push_op(K_LOAD, 32'h20, 2'd0, 1'b1, 32'h0, g);
        push_op(K_FETCH, 32'h3000, 2'd2, 1'b0, 32'h0, g + 4);
        wait_done(1'b0);
        mem_load_in = 1'b0;
        wait_done(1'b1);
        if_req_in = 1'b0;

        // Half store, then read it back signed.
        do_op(K_STORE, 32'h104, 2'd1, 1'b0, 32'h0000BEEF);
        do_op(K_LOAD, 32'h104, 2'd1, 1'b1, 32'h0);

        // Word load wrapping the top of the address space; unsigned half.
        poke(32'hFFFFFFFE, 8'h11); poke(32'hFFFFFFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);
        do_op(K_LOAD, 32'hFFFFFFFE, 2'd2, 1'b0, 32'h0);
        poke(32'h200, 8'h01); poke(32'h201, 8'h80);
        do_op(K_LOAD, 32'h200, 2'd1, 1'b0, 32'h0);

        // Cancel a fetch during byte 2 while a load waits.
        @(posedge clk_in);
        #1;
        g = cyc;
        if_req_in = 1'b1; if_addr_in = 32'h2000;
        for (int k = 0; k < 3; k++) begin
            bus_t b;
            b.cyc = g + 1 + k; b.a = 32'h2000 + 32'(k); b.wr = 1'b0; b.d = '0;
            bq.push_back(b);
        end
        repeat (2) @(posedge clk_in);
        #1;
        mem_load_in = 1'b1; mem_addr_in = 32'h300; mem_width_in = 2'd2; mem_signed_in = 1'b0;
        push_op(K_LOAD, 32'h300, 2'd2, 1'b0, 32'h0, g + 4);
        @(posedge clk_in);
        #1;
        if_cancel_in = 1'b1;
        @(posedge clk_in);
        #1;
        if_cancel_in = 1'b0;
        if_req_in = 1'b0;
        wait_done(1'b0);
        mem_load_in = 1'b0;

        // Reset in the middle of a word store (byte 1 on the bus).
        @(posedge clk_in);
        #1;
        g = cyc;
        mem_store_in = 1'b1; mem_addr_in = 32'h400; mem_width_in = 2'd2; mem_wdata_in = 32'h11223344;
        begin
            bus_t b;
            b.cyc = g + 1; b.a = 32'h400; b.wr = 1'b1; b.d = 8'h44;
            bq.push_back(b);
            ref_mem[32'h400] = 8'h44;
        end
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        mem_store_in = 1'b0;
        cur_data_done_cyc = -1;
        #1;
        chk_reset_outputs("midstore_reset");
        repeat (2) @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        do_op(K_LOAD, 32'h400, 2'd2, 1'b0, 32'h0);

        // Randomized mix of fetches, loads and stores.
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else a = 32'h100 + 32'($urandom_range(0, 63));
            do_op(kind, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk_in);
        end

        repeat (5) @(posedge clk_in);
        #1;
        chk("bus_queue_drained", bq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller that shares the single 8-bit synchronous RAM port between the instruction-fetch stage and the MEM stage (loads/stores produced by `ex`). It grants one requester at a time, sequences the 1/2/4-byte transfers one byte per cycle, assembles and sign-extends read data, and raises a stall request to the pipeline controller while a data access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: width of all addresses.

Ports:
- `clk_in`  in  1: single clock; all state updates on the rising edge.
- `rst_in`  in  1: reset, asynchronous, active-low.
- `if_req_in`  in  1: fetch request, held level until done or cancel.
- `if_addr_in`  in  ADDR_W: fetch address.
- `if_cancel_in`  in  1: branch flush; aborts a pending or in-flight fetch.
- `if_data_out`  out  32: fetched instruction, valid while `if_done_out`.
- `if_done_out`  out  1: one-cycle fetch-complete pulse.
- `mem_load_in`, `mem_store_in`  in  1 each: data request, held level until done.
- `mem_addr_in`  in  ADDR_W: data address.
- `mem_wdata_in`  in  32: store data, low bytes used.
- `mem_width_in`  in  2: 0 byte, 1 half, 2 word; 3 treated as word.
- `mem_signed_in`  in  1: sign-extend load result.
- `mem_rdata_out`  out  32: load result, valid while `mem_done_out`.
- `mem_done_out`  out  1: one-cycle data-complete pulse.
- `ram_din_in`  in  8: RAM read data, one cycle after address.
- `ram_dout_out`  out  8: RAM write data.
- `ram_a_out`  out  ADDR_W: RAM address.
- `ram_wr_out`  out  1: 1 write, 0 read.
- `stallreq_out`  out  1: stall request to pipeline control.

## Operation
- States: IDLE, IF_RD, LD_RD, ST_WR, DONE.
- IDLE: if load or store pending, grant data port (priority over fetch); else if `if_req_in` and not `if_cancel_in`, grant fetch. Request operands latched at grant. No grant in any other state; no preemption.
- N = 1/2/4 from width (fetch always 4). Byte counter k counts 0..N-1, little-endian: byte k at address+k, modulo 2^ADDR_W.
- IF_RD/LD_RD: issue address+k; byte k captured one cycle later into bits [8k+7:8k]. After last byte captured → DONE.
- ST_WR: drive `ram_wr_out`=1, address+k, `mem_wdata_in` byte k. After byte N-1 → DONE.
- DONE: one cycle, pulse the matching done output, then IDLE. Requester must drop or change its request before the end of the DONE cycle.
- Load result: byte/half zero- or sign-extended per `mem_signed_in`; word unchanged.
- `if_cancel_in` in IF_RD: next edge → IDLE, no `if_done_out`, captured bytes discarded. No effect on data accesses.
- `stallreq_out` = (`mem_load_in` | `mem_store_in`) & ~`mem_done_out` (combinational).
- Load and store asserted together: illegal; load wins.

## Timing
- Reset (async, any state, mid-transfer included): state IDLE, k=0, `ram_wr_out`=0, `ram_a_out`=0, `ram_dout_out`=0, both done outputs 0, `if_data_out`=0, `mem_rdata_out`=0. Partial stores are not rolled back.
- Outputs to RAM are registered. Request sampled in IDLE cycle 0.
- Read of N bytes: address+k in cycle 1+k; `ram_din_in` for byte k sampled end of cycle 2+k; done in cycle N+2. Fetch: done in cycle 6.
- Write of N bytes: write in cycles 1..N; done in cycle N+1.
- Outside ST_WR, `ram_wr_out`=0 at all times.
- Back-to-back: next grant no earlier than the cycle after DONE.

## Structure
- `defines.v` gains: width codes (`MemByte`, `MemHalf`, `MemWord`), state encodings, `ReadEnable`/`WriteEnable` reuse.
- Single module; the sign/zero extension is natural as sub-module `mem_ext` (combinational, width + signed + raw word → result).

## Test plan
- Fetch at 0x1000, RAM bytes 13 05 00 00 → `ram_a_out` 0x1000..0x1003 cycles 1–4, `if_data_out`=0x00000513 with `if_done_out` in cycle 6.
- Fetch and LB at 0x20 (byte 0x80, signed) requested same cycle → data granted first, `mem_rdata_out`=0xFFFFFF80 cycle 3, fetch starts after DONE.
- SH 0xBEEF to 0x104 → `ram_wr_out`=1 cycles 1–2 with (0x104,0xEF),(0x105,0xBE); `mem_done_out` cycle 3; `stallreq_out` high cycles 0–2.
- LW at 0xFFFFFFFE → addresses wrap 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1; LHU of 0x8001 → 0x00008001.
- `if_cancel_in` during fetch byte 2 → IDLE next edge, no `if_done_out`; pending load granted next cycle.
- `rst_in` low mid-store (byte 1) → `ram_wr_out` 0 immediately, all outputs reset values; new request after release completes normally.
